// File: rtl/dm_sba_v2.sv
// System bus access master for the debug module: launches single reads/writes on
// sbaddress/sbdata events, lane-aligns data, and reports size/alignment/bus/timeout errors.
module dm_sba_v2 #(
    parameter int unsigned BusWidth      = 32,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    dmactive_i,

    output logic                    master_req_o,
    output logic [BusWidth-1:0]     master_add_o,
    output logic                    master_we_o,
    output logic [BusWidth-1:0]     master_wdata_o,
    output logic [BusWidth/8-1:0]   master_be_o,
    input  logic                    master_gnt_i,
    input  logic                    master_r_valid_i,
    input  logic                    master_r_err_i,
    input  logic [BusWidth-1:0]     master_r_rdata_i,

    input  logic [BusWidth-1:0]     sbaddress_i,
    input  logic                    sbaddress_write_valid_i,
    input  logic                    sbreadonaddr_i,
    input  logic                    sbautoincrement_i,
    input  logic [2:0]              sbaccess_i,
    input  logic                    sbreadondata_i,
    input  logic [BusWidth-1:0]     sbdata_i,
    input  logic                    sbdata_read_valid_i,
    input  logic                    sbdata_write_valid_i,

    output logic [BusWidth-1:0]     sbaddress_o,
    output logic [BusWidth-1:0]     sbdata_o,
    output logic                    sbdata_valid_o,
    output logic                    sbbusy_o,
    output logic                    sbbusyerror_o,
    output logic                    sberror_valid_o,
    output logic [2:0]              sberror_o
);

    localparam int NumBytes = BusWidth / 8;
    localparam int OffW     = $clog2(NumBytes);
    localparam int CntW     = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntW-1:0] CntLoad   = (TimeoutCycles > 0) ? CntW'(TimeoutCycles - 1) : '0;
    localparam logic [2:0]      MaxAccess = 3'(OffW);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_WAIT_READ,
        ST_WAIT_WRITE
    } state_e;

    state_e                state_q, state_d;
    logic [BusWidth-1:0]   addr_q, addr_d;
    logic [2:0]            size_q, size_d;
    logic [BusWidth-1:0]   wdata_q, wdata_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  err_valid_q, err_valid_d;
    logic [2:0]            err_code_q, err_code_d;
    logic                  busyerr_q, busyerr_d;

    logic                  busy;
    logic                  launch_wr, launch_rd;
    logic                  timeout_hit;
    logic                  resp_ok;
    logic [7:0]            size_bytes_in;

    int                    off_int;
    int                    n_int;
    logic [BusWidth-1:0]   rdata_sh;
    logic [BusWidth-1:0]   wdata_rep;
    logic [BusWidth-1:0]   rdata_al;
    logic [NumBytes-1:0]   be;

    assign busy          = (state_q != ST_IDLE);
    assign timeout_hit   = (TimeoutCycles != 0) && (cnt_q == '0);
    assign size_bytes_in = 8'd1 << sbaccess_i;
    assign launch_wr     = sbdata_write_valid_i;
    assign launch_rd     = !sbdata_write_valid_i &&
                           ((sbdata_read_valid_i && sbreadondata_i) ||
                            (sbaddress_write_valid_i && sbreadonaddr_i));

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        size_d      = size_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        err_valid_d = 1'b0;
        err_code_d  = 3'd0;
        busyerr_d   = busy && (sbaddress_write_valid_i || sbdata_read_valid_i ||
                               sbdata_write_valid_i);

        case (state_q)
            ST_IDLE: begin
                cnt_d = CntLoad;
                if (launch_wr || launch_rd) begin
                    if (sbaccess_i > MaxAccess) begin
                        err_valid_d = 1'b1;
                        err_code_d  = 3'd4;
                    end else if ((sbaddress_i[OffW-1:0] & OffW'(size_bytes_in - 8'd1)) != '0) begin
                        err_valid_d = 1'b1;
                        err_code_d  = 3'd3;
                    end else begin
                        addr_d  = sbaddress_i;
                        size_d  = sbaccess_i;
                        if (launch_wr) begin
                            wdata_d = sbdata_i;
                        end
                        state_d = launch_wr ? ST_WRITE : ST_READ;
                    end
                end
            end
            ST_READ, ST_WRITE: begin
                cnt_d = cnt_q - 1'b1;
                if (timeout_hit) begin
                    state_d     = ST_IDLE;
                    err_valid_d = 1'b1;
                    err_code_d  = 3'd1;
                end else if (master_gnt_i) begin
                    state_d = (state_q == ST_READ) ? ST_WAIT_READ : ST_WAIT_WRITE;
                end
            end
            ST_WAIT_READ, ST_WAIT_WRITE: begin
                cnt_d = cnt_q - 1'b1;
                // A response in the same cycle as the timeout still completes the transfer.
                if (master_r_valid_i) begin
                    state_d = ST_IDLE;
                    if (master_r_err_i) begin
                        err_valid_d = 1'b1;
                        err_code_d  = 3'd2;
                    end
                end else if (timeout_hit) begin
                    state_d     = ST_IDLE;
                    err_valid_d = 1'b1;
                    err_code_d  = 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || !dmactive_i) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            size_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= 3'd0;
            busyerr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            busyerr_q   <= busyerr_d;
        end
    end

    // Lane handling from the latched address offset and access size.
    always_comb begin
        off_int   = int'(addr_q[OffW-1:0]);
        n_int     = 1 << size_q;
        rdata_sh  = master_r_rdata_i >> (8 * off_int);
        be        = '0;
        wdata_rep = '0;
        rdata_al  = '0;
        for (int i = 0; i < NumBytes; i++) begin
            be[i]              = (i >= off_int) && (i < off_int + n_int);
            wdata_rep[8*i +: 8] = wdata_q[8*(i & (n_int - 1)) +: 8];
            rdata_al[8*i +: 8]  = (i < n_int) ? rdata_sh[8*i +: 8] : 8'h00;
        end
    end

    assign resp_ok = ((state_q == ST_WAIT_READ) || (state_q == ST_WAIT_WRITE)) &&
                     master_r_valid_i && !master_r_err_i;

    assign master_req_o    = (state_q == ST_READ) || (state_q == ST_WRITE);
    assign master_we_o     = (state_q == ST_WRITE) || (state_q == ST_WAIT_WRITE);
    assign master_add_o    = addr_q;
    assign master_be_o     = be;
    assign master_wdata_o  = wdata_rep;

    assign sbdata_o        = rdata_al;
    assign sbdata_valid_o  = (state_q == ST_WAIT_READ) && master_r_valid_i && !master_r_err_i;
    assign sbaddress_o     = (resp_ok && sbautoincrement_i) ? addr_q + BusWidth'(n_int) : sbaddress_i;
    assign sbbusy_o        = busy;
    assign sbbusyerror_o   = busyerr_q;
    assign sberror_valid_o = err_valid_q;
    assign sberror_o       = err_code_q;

endmodule

// File: tb/tb_dm_sba_v2.sv
// Directed bench for dm_sba_v2 (32-bit bus, 8-cycle timeout) with a per-cycle
// transaction-level reference model and literal spot checks.
module tb_dm_sba_v2;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n, dmactive;
    logic        req, we, gnt, r_valid, r_err;
    logic [31:0] add, wdata, rdata;
    logic [3:0]  be;
    logic [31:0] sbaddress_i, sbdata_i, sbaddress_o, sbdata_o;
    logic        addr_wv, readonaddr, autoinc, readondata, data_rv, data_wv;
    logic [2:0]  sbaccess;
    logic        sbdata_valid, busy, busyerr, err_valid;
    logic [2:0]  err_code;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dm_sba_v2 #(.BusWidth(32), .TimeoutCycles(TO)) dut (
        .clk_i                   (clk),
        .rst_ni                  (rst_n),
        .dmactive_i              (dmactive),
        .master_req_o            (req),
        .master_add_o            (add),
        .master_we_o             (we),
        .master_wdata_o          (wdata),
        .master_be_o             (be),
        .master_gnt_i            (gnt),
        .master_r_valid_i        (r_valid),
        .master_r_err_i          (r_err),
        .master_r_rdata_i        (rdata),
        .sbaddress_i             (sbaddress_i),
        .sbaddress_write_valid_i (addr_wv),
        .sbreadonaddr_i          (readonaddr),
        .sbautoincrement_i       (autoinc),
        .sbaccess_i              (sbaccess),
        .sbreadondata_i          (readondata),
        .sbdata_i                (sbdata_i),
        .sbdata_read_valid_i     (data_rv),
        .sbdata_write_valid_i    (data_wv),
        .sbaddress_o             (sbaddress_o),
        .sbdata_o                (sbdata_o),
        .sbdata_valid_o          (sbdata_valid),
        .sbbusy_o                (busy),
        .sbbusyerror_o           (busyerr),
        .sberror_valid_o         (err_valid),
        .sberror_o               (err_code)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: transfer phase 0=idle, 1=requesting, 2=awaiting response.
    int          m_phase = 0;
    int          m_size  = 0;
    int          m_el    = 0;
    logic        m_we    = 1'b0;
    logic [31:0] m_addr  = '0;
    logic [31:0] m_wdata = '0;
    logic [2:0]  m_err   = '0;
    logic        m_berr  = 1'b0;

    initial begin
        logic [31:0] e_addr, e_rd, e_wd, lowmask;
        logic [3:0]  e_be;
        logic [2:0]  nerr;
        logic        resp, ok;
        int          n, off;
        @(posedge clk);
        forever begin
            @(negedge clk);
            n       = 1 << m_size;
            off     = int'(m_addr % 32'd4);
            lowmask = 32'((64'd1 << (8 * n)) - 64'd1);
            resp    = (m_phase == 2) && r_valid;
            ok      = resp && !r_err;

            chk("req", req, m_phase == 1);
            chk("busy", busy, m_phase != 0);
            chk("err_valid", err_valid, m_err != 3'd0);
            chk("err_code", err_code, m_err);
            chk("busyerr", busyerr, m_berr);
            e_addr = (ok && autoinc) ? m_addr + 32'(n) : sbaddress_i;
            chk("sbaddress", sbaddress_o, e_addr);
            chk("sbdata_valid", sbdata_valid, ok && !m_we);
            if (m_phase == 1) begin
                e_be = 4'(((1 << n) - 1) << off);
                chk("addr", add, m_addr);
                chk("we", we, m_we);
                chk("be", be, e_be);
                if (m_we) begin
                    e_wd = '0;
                    for (int k = 0; k < 4 / n; k++)
                        e_wd = e_wd | ((m_wdata & lowmask) << (8 * n * k));
                    chk("wdata", wdata, e_wd);
                end
            end
            if (ok && !m_we) begin
                e_rd = 32'(rdata >> (8 * off)) & lowmask;
                chk("sbdata", sbdata_o, e_rd);
            end

            if (!rst_n || !dmactive) begin
                m_phase = 0; m_err = '0; m_berr = 1'b0; m_el = 0;
            end else begin
                m_berr = (m_phase != 0) && (addr_wv || data_rv || data_wv);
                nerr   = '0;
                if (m_phase == 0) begin
                    if (data_wv || (data_rv && readondata) || (addr_wv && readonaddr)) begin
                        if (sbaccess > 3'd2) nerr = 3'd4;
                        else if ((sbaddress_i % (32'd1 << sbaccess)) != 32'd0) nerr = 3'd3;
                        else begin
                            m_we = data_wv; m_addr = sbaddress_i; m_size = int'(sbaccess);
                            m_wdata = sbdata_i; m_el = 0; m_phase = 1;
                        end
                    end
                end else begin
                    m_el++;
                    if (resp) begin
                        m_phase = 0;
                        if (r_err) nerr = 3'd2;
                    end else if (m_el == TO) begin
                        m_phase = 0; nerr = 3'd1;
                    end else if (m_phase == 1 && gnt) begin
                        m_phase = 2;
                    end
                end
                m_err = nerr;
            end
        end
    end

    initial begin
        int req_cycles;
        rst_n = 1'b0; dmactive = 1'b1;
        gnt = 0; r_valid = 0; r_err = 0; rdata = '0;
        sbaddress_i = '0; sbdata_i = '0; sbaccess = 3'd2;
        addr_wv = 0; readonaddr = 0; autoinc = 0; readondata = 0; data_rv = 0; data_wv = 0;
        repeat (3) tick();
        chk("rst_req", req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err_valid", err_valid, 1'b0);
        rst_n = 1'b1;
        tick();

        // Halfword read on address write, auto-increment
        sbaddress_i = 32'h1000_0002; sbaccess = 3'd1; readonaddr = 1; autoinc = 1; addr_wv = 1;
        tick();
        addr_wv = 0;
        chk("t1_req", req, 1'b1);
        chk("t1_be", be, 4'b1100);
        chk("t1_we", we, 1'b0);
        repeat (2) tick();
        gnt = 1; tick(); gnt = 0;
        chk("t1_req_drop", req, 1'b0);
        r_valid = 1; rdata = 32'hBEEF_0000;
        #1;
        chk("t1_sbdata", sbdata_o, 32'h0000_BEEF);
        chk("t1_sbdata_valid", sbdata_valid, 1'b1);
        chk("t1_sbaddress", sbaddress_o, 32'h1000_0004);
        tick(); r_valid = 0; readonaddr = 0;
        chk("t1_idle", busy, 1'b0);

        // Byte write; read-on-data in the same cycle loses to the write
        sbaddress_i = 32'h2000_0003; sbaccess = 3'd0; sbdata_i = 32'h0000_00A5;
        data_wv = 1; data_rv = 1; readondata = 1;
        tick();
        data_wv = 0; data_rv = 0;
        chk("t2_we", we, 1'b1);
        chk("t2_wdata", wdata, 32'hA5A5_A5A5);
        chk("t2_be", be, 4'b1000);
        gnt = 1; tick(); gnt = 0;
        r_valid = 1;
        #1;
        chk("t2_sbaddress", sbaddress_o, 32'h2000_0004);
        chk("t2_no_sbdata_valid", sbdata_valid, 1'b0);
        tick(); r_valid = 0;

        // Misaligned word read: no request, error 3
        sbaddress_i = 32'h2000_0002; sbaccess = 3'd2; readonaddr = 1; addr_wv = 1;
        tick();
        addr_wv = 0;
        chk("t3_req", req, 1'b0);
        chk("t3_err_valid", err_valid, 1'b1);
        chk("t3_err_code", err_code, 3'd3);
        tick();
        chk("t3_err_cleared", err_code, 3'd0);

        // Oversized access: error 4
        sbaddress_i = 32'h0000_0000; sbaccess = 3'd3; data_wv = 1;
        tick();
        data_wv = 0;
        chk("t4_req", req, 1'b0);
        chk("t4_err_code", err_code, 3'd4);
        tick();

        // Timeout with grant held low
        sbaddress_i = 32'h3000_0000; sbaccess = 3'd2; data_rv = 1; readondata = 1;
        tick();
        data_rv = 0;
        req_cycles = 0;
        for (int k = 0; k < 20; k++) begin
            if (!req) break;
            req_cycles++;
            tick();
        end
        chk("t5_req_cycles", req_cycles, TO);
        chk("t5_err_valid", err_valid, 1'b1);
        chk("t5_err_code", err_code, 3'd1);
        chk("t5_idle", busy, 1'b0);
        tick();

        // Busy violation during WaitRead, then completion
        sbaddress_i = 32'h4000_0004; sbaccess = 3'd2; autoinc = 1; data_rv = 1;
        tick();
        data_rv = 0;
        gnt = 1; tick(); gnt = 0;
        data_wv = 1; sbdata_i = 32'h0000_1234;
        tick();
        data_wv = 0;
        chk("t6_busyerr", busyerr, 1'b1);
        chk("t6_busy", busy, 1'b1);
        r_valid = 1; rdata = 32'hCAFE_F00D;
        #1;
        chk("t6_sbdata", sbdata_o, 32'hCAFE_F00D);
        chk("t6_sbaddress", sbaddress_o, 32'h4000_0008);
        tick(); r_valid = 0;
        chk("t6_no_write_req", req, 1'b0);
        tick();
        chk("t6_still_idle", busy, 1'b0);

        // Bus error response
        sbaddress_i = 32'h4000_0008; data_rv = 1;
        tick();
        data_rv = 0;
        gnt = 1; tick(); gnt = 0;
        r_valid = 1; r_err = 1;
        #1;
        chk("t7_no_sbdata_valid", sbdata_valid, 1'b0);
        chk("t7_sbaddress", sbaddress_o, 32'h4000_0008);
        tick(); r_valid = 0; r_err = 0;
        chk("t7_err_code", err_code, 3'd2);
        tick();

        // dmactive drop mid-transfer, then stray responses
        sbaddress_i = 32'h5000_0000; sbaccess = 3'd2; sbdata_i = 32'h1122_3344; data_wv = 1;
        tick();
        data_wv = 0;
        chk("t8_wdata", wdata, 32'h1122_3344);
        dmactive = 0; tick(); dmactive = 1;
        chk("t8_req", req, 1'b0);
        chk("t8_busy", busy, 1'b0);
        gnt = 1; r_valid = 1; r_err = 1;
        #1;
        chk("t8_stray_valid", sbdata_valid, 1'b0);
        tick(); gnt = 0; r_valid = 0; r_err = 0;
        chk("t8_stray_err", err_valid, 1'b0);
        chk("t8_stray_req", req, 1'b0);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
